linebuffer_writer: RTL

Draw-domain producer for the double-buffered 16-pixel-wide line buffers. It accepts a stream of single pixels (x, colour) from the sprite/tile renderers and packs them into 128-bit words with per-pixel byte enables. These words drive the off-screen write port. On each line flip it also toggles the draw-side buffer select and sweeps zeros across the on-screen buffer through the clear port.

---
 rtl/linebuffer_pkg.sv | 24 ++
 rtl/linebuffer_writer_if.sv | 13 +
 rtl/linebuffer_clearer.sv | 36 +++
 rtl/linebuffer_writer.sv | 132 +++++++++++++
 4 files changed

// File: rtl/linebuffer_pkg.sv
// Shared types and constants for the draw-side line buffer writer.
package linebuffer_pkg;

    localparam int PIX_PER_WORD = 16;
    localparam int LB_WORDS_MAX = 128;

    typedef logic [7:0]   colour_t;
    typedef logic [6:0]   word_addr_t;
    typedef logic [3:0]   lane_t;
    typedef logic [127:0] lb_word_t;
    typedef logic [15:0]  lb_we_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAW  = 2'd1,
        ST_FLUSH = 2'd2
    } writer_state_t;

    // One-hot byte enable for a single pixel lane.
    function automatic lb_we_t lane_onehot(input lane_t lane);
        return lb_we_t'(1) << lane;
    endfunction

endpackage

// File: rtl/linebuffer_writer_if.sv
// Pixel stream from the sprite/tile renderers into the line buffer writer.
interface linebuffer_writer_if;
    import linebuffer_pkg::*;

    logic    px_valid;
    logic    px_ready;
    logic    [10:0] px_x;
    colour_t px_colour;

    modport master (output px_valid, output px_x, output px_colour, input px_ready);
    modport slave  (input px_valid, input px_x, input px_colour, output px_ready);

endinterface

// File: rtl/linebuffer_clearer.sv
// Sweeps one word per cycle across the on-screen buffer after each line flip.
module linebuffer_clearer
    import linebuffer_pkg::*;
#(
    parameter int LINE_WORDS = 80
) (
    input  logic       clk_draw,
    input  logic       rst_n,
    input  logic       start,
    output logic       busy,
    output logic       we,
    output word_addr_t addr
);

    localparam word_addr_t LAST_ADDR = word_addr_t'(LINE_WORDS - 1);

    // Restart at word 0 on every flip, then walk up to the last word and stop.
    always_ff @(posedge clk_draw or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            addr <= '0;
        end else if (start) begin
            busy <= 1'b1;
            addr <= '0;
        end else if (busy) begin
            if (addr == LAST_ADDR) begin
                busy <= 1'b0;
            end else begin
                addr <= addr + word_addr_t'(1);
            end
        end
    end

    assign we = busy;

endmodule

// File: rtl/linebuffer_writer.sv
// Packs single pixels into 16-pixel words for the off-screen buffer and
// drives the clear sweep of the on-screen buffer on each line flip.
module linebuffer_writer
    import linebuffer_pkg::*;
#(
    parameter int      LINE_WORDS  = 80,
    parameter colour_t TRANSPARENT = 8'h00
) (
    input  logic       clk_draw,
    input  logic       rst_n,
    input  logic       line_start,
    input  logic       line_done,
    linebuffer_writer_if.slave px,
    output logic       buffsel_draw,
    output word_addr_t addr_on_draw,
    output logic       we_on_draw,
    output lb_word_t   colour_on_draw,
    output word_addr_t addr_off_draw,
    output lb_we_t     we_off_draw,
    output lb_word_t   colour_off_draw,
    output logic       clear_busy,
    output logic       done
);

    localparam logic [7:0] LINE_WORDS_8 = 8'(LINE_WORDS);

    writer_state_t state;

    logic       acc_valid;
    word_addr_t acc_addr;
    lb_we_t     acc_we;
    lb_word_t   acc_data;

    word_addr_t px_word;
    lane_t      px_lane;
    logic       px_take;
    lb_word_t   lane_data;
    lb_word_t   lane_mask;

    assign px.px_ready    = (state == ST_DRAW);
    assign colour_on_draw = '0;

    // Decode the incoming pixel into word/lane and decide whether it lands.
    always_comb begin
        px_word   = px.px_x[10:4];
        px_lane   = px.px_x[3:0];
        px_take   = px.px_valid && (state == ST_DRAW)
                    && (px.px_colour != TRANSPARENT)
                    && ({1'b0, px_word} < LINE_WORDS_8);
        lane_data = lb_word_t'(px.px_colour) << {px_lane, 3'b000};
        lane_mask = lb_word_t'(8'hFF) << {px_lane, 3'b000};
    end

    // FSM, accumulator and registered off-screen write port.
    always_ff @(posedge clk_draw or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            buffsel_draw    <= 1'b0;
            acc_valid       <= 1'b0;
            acc_addr        <= '0;
            acc_we          <= '0;
            acc_data        <= '0;
            addr_off_draw   <= '0;
            we_off_draw     <= '0;
            colour_off_draw <= '0;
            done            <= 1'b0;
        end else begin
            we_off_draw <= '0;
            done        <= 1'b0;
            if (line_start) begin
                // A pending word belongs to the old line and is dropped.
                state        <= ST_DRAW;
                buffsel_draw <= ~buffsel_draw;
                acc_valid    <= 1'b0;
                acc_we       <= '0;
                acc_data     <= '0;
            end else begin
                case (state)
                    ST_DRAW: begin
                        if (px_take) begin
                            if (acc_valid && (px_word != acc_addr)) begin
                                addr_off_draw   <= acc_addr;
                                we_off_draw     <= acc_we;
                                colour_off_draw <= acc_data;
                                acc_we          <= lane_onehot(px_lane);
                                acc_data        <= lane_data;
                            end else begin
                                acc_we          <= acc_we | lane_onehot(px_lane);
                                acc_data        <= (acc_data & ~lane_mask) | lane_data;
                            end
                            acc_valid <= 1'b1;
                            acc_addr  <= px_word;
                        end
                        if (line_done) begin
                            state <= ST_FLUSH;
                        end
                    end
                    ST_FLUSH: begin
                        if (acc_valid) begin
                            addr_off_draw   <= acc_addr;
                            we_off_draw     <= acc_we;
                            colour_off_draw <= acc_data;
                            acc_valid       <= 1'b0;
                            acc_we          <= '0;
                            acc_data        <= '0;
                        end else begin
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end
                    ST_IDLE: begin
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    linebuffer_clearer #(
        .LINE_WORDS (LINE_WORDS)
    ) u_clearer (
        .clk_draw (clk_draw),
        .rst_n    (rst_n),
        .start    (line_start),
        .busy     (clear_busy),
        .we       (we_on_draw),
        .addr     (addr_on_draw)
    );

endmodule
